// File: rtl/ts4231_pkg.sv
// ts4231_pkg: state encoding and default timing shared by the TS4231 scheduler and init engine.
package ts4231_pkg;
    typedef enum logic [2:0] {IDLE, HRST, START, WAIT_DONE, NEXT, RUN} state_t;
    localparam int HARD_RESET_CYCLES_DEF = 480;
    localparam int CFG_TIMEOUT_CYCLES_DEF = 4_800_000;
    localparam int MAX_RETRIES_DEF = 3;
    function automatic int sel_width(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ts4231_cfg_scheduler_if.sv
// ts4231_cfg_scheduler_if: per-sensor init-engine strobes plus the capture grant handshake.
interface ts4231_cfg_scheduler_if import ts4231_pkg::*; #(
    parameter int N = 4
);
    localparam int SW = sel_width(N);
    logic [N-1:0] hard_reset;
    logic [N-1:0] cfg_start;
    logic [N-1:0] cfg_done;
    logic [N-1:0] start_watch;
    logic [N-1:0] capture_done;
    logic [SW-1:0] grant_sel;
    logic grant_valid;
    logic grant_ready;
    modport master (
        output hard_reset, cfg_start, start_watch, grant_sel, grant_valid,
        input cfg_done, capture_done, grant_ready
    );
    modport slave (
        input hard_reset, cfg_start, start_watch, grant_sel, grant_valid,
        output cfg_done, capture_done, grant_ready
    );
endinterface

// File: rtl/ts4231_rr_arbiter.sv
// ts4231_rr_arbiter: picks the first requesting index strictly after ptr, wrapping at N-1.
module ts4231_rr_arbiter import ts4231_pkg::*; #(
    parameter int N = 4,
    parameter int SW = sel_width(N)
) (
    input logic [N-1:0] req,
    input logic [SW-1:0] ptr,
    output logic [SW-1:0] sel,
    output logic any
);
    // Scanning from the farthest candidate back lets the nearest request win.
    always_comb begin
        sel = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[SW'((int'(ptr) + k) % N)]) sel = SW'((int'(ptr) + k) % N);
        end
    end
    assign any = |req;
endmodule

// File: rtl/ts4231_cfg_scheduler.sv
// ts4231_cfg_scheduler: sequences hard reset and configuration of each TS4231 front-end,
// then arbitrates capture completions round-robin while running.
module ts4231_cfg_scheduler import ts4231_pkg::*; #(
    parameter int NUMBER_OF_SENSORS = 4,
    parameter int HARD_RESET_CYCLES = HARD_RESET_CYCLES_DEF,
    parameter int CFG_TIMEOUT_CYCLES = CFG_TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRIES = MAX_RETRIES_DEF
) (
    input logic clock,
    input logic reset_n,
    input logic enable,
    ts4231_cfg_scheduler_if.master bus,
    output logic [NUMBER_OF_SENSORS-1:0] sensor_ok,
    output logic [NUMBER_OF_SENSORS-1:0] sensor_failed,
    output logic busy,
    output logic all_done
);
    localparam int N = NUMBER_OF_SENSORS;
    localparam int SW = sel_width(N);
    localparam int HW = $clog2(HARD_RESET_CYCLES + 1);
    localparam int TW = $clog2(CFG_TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    state_t state;
    logic [SW-1:0] idx, ptr, arb_sel;
    logic [HW-1:0] hcnt;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] retry;
    logic [N-1:0] pending, idx_oh, sel_oh;
    logic arb_any, hs;

    assign idx_oh = N'(1) << idx;
    assign sel_oh = N'(1) << bus.grant_sel;
    assign hs = bus.grant_valid & bus.grant_ready;
    assign busy = state != IDLE && state != RUN;
    assign all_done = state == RUN;

    ts4231_rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req(pending),
        .ptr(ptr),
        .sel(arb_sel),
        .any(arb_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx <= '0;
            ptr <= '0;
            hcnt <= '0;
            tcnt <= '0;
            retry <= '0;
            pending <= '0;
            sensor_ok <= '0;
            sensor_failed <= '0;
            bus.hard_reset <= '0;
            bus.cfg_start <= '0;
            bus.start_watch <= '0;
            bus.grant_sel <= '0;
            bus.grant_valid <= 1'b0;
        end else if (!enable) begin
            state <= IDLE;
            pending <= '0;
            bus.hard_reset <= '0;
            bus.cfg_start <= '0;
            bus.start_watch <= '0;
            bus.grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sensor_ok <= '0;
                    sensor_failed <= '0;
                    idx <= '0;
                    retry <= '0;
                    hcnt <= '0;
                    bus.hard_reset <= N'(1);
                    state <= HRST;
                end
                HRST: begin
                    if (hcnt == HW'(HARD_RESET_CYCLES - 1)) begin
                        bus.hard_reset <= '0;
                        bus.cfg_start <= idx_oh;
                        state <= START;
                    end else hcnt <= hcnt + 1'b1;
                end
                START: begin
                    bus.cfg_start <= '0;
                    tcnt <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done seen on the timeout cycle still counts as success.
                    if (|(bus.cfg_done & idx_oh)) begin
                        sensor_ok <= sensor_ok | idx_oh;
                        state <= NEXT;
                    end else if (tcnt == TW'(CFG_TIMEOUT_CYCLES - 1)) begin
                        retry <= retry + 1'b1;
                        if (int'(retry) + 1 < MAX_RETRIES) begin
                            hcnt <= '0;
                            bus.hard_reset <= idx_oh;
                            state <= HRST;
                        end else begin
                            sensor_failed <= sensor_failed | idx_oh;
                            state <= NEXT;
                        end
                    end else tcnt <= tcnt + 1'b1;
                end
                NEXT: begin
                    retry <= '0;
                    if (idx == SW'(N - 1)) begin
                        bus.start_watch <= sensor_ok;
                        ptr <= SW'(N - 1);
                        state <= RUN;
                    end else begin
                        idx <= idx + 1'b1;
                        hcnt <= '0;
                        bus.hard_reset <= idx_oh << 1;
                        state <= HRST;
                    end
                end
                RUN: begin
                    pending <= (pending & ~(hs ? sel_oh : '0)) | (bus.capture_done & sensor_ok);
                    if (hs) begin
                        bus.grant_valid <= 1'b0;
                        ptr <= bus.grant_sel;
                    end else if (!bus.grant_valid && arb_any) begin
                        bus.grant_valid <= 1'b1;
                        bus.grant_sel <= arb_sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ts4231_cfg_scheduler.sv
// tb_ts4231_cfg_scheduler: random sensor responses and capture bursts checked against
// a behavioural sequencing and round-robin model.
module tb_ts4231_cfg_scheduler;
    localparam int N = 4;
    localparam int H = 480;
    localparam int T = 1000;
    localparam int M = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic [N-1:0] sensor_ok, sensor_failed;
    logic busy, all_done;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int model_last = -1;
    bit [N-1:0] respond = '0;
    int dly[N];
    int hr_len[N];
    int start_cnt[N];
    int last_start[N];
    int done_at[N];
    int hr_s[$], hr_l[$], gap_q[$], grant_q[$], grant_cyc[$], exp_q[$];

    ts4231_cfg_scheduler_if #(.N(N)) bus();

    ts4231_cfg_scheduler #(
        .NUMBER_OF_SENSORS(N),
        .HARD_RESET_CYCLES(H),
        .CFG_TIMEOUT_CYCLES(T),
        .MAX_RETRIES(M)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .bus(bus),
        .sensor_ok(sensor_ok),
        .sensor_failed(sensor_failed),
        .busy(busy),
        .all_done(all_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon();
        hr_s.delete();
        hr_l.delete();
        gap_q.delete();
        for (int i = 0; i < N; i++) begin
            hr_len[i] = 0;
            start_cnt[i] = 0;
            last_start[i] = -1;
            done_at[i] = -1;
        end
    endtask

    // Sensor model: answers cfg_start after dly cycles if it responds, forgets on hard reset.
    initial begin
        bus.cfg_done = '0;
        clear_mon();
        forever begin
            @(negedge clock);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (bus.hard_reset[i]) begin
                    if (hr_len[i] == 0 && last_start[i] >= 0) gap_q.push_back(cyc - last_start[i]);
                    hr_len[i]++;
                    bus.cfg_done[i] = 1'b0;
                    done_at[i] = -1;
                end else if (hr_len[i] > 0) begin
                    hr_s.push_back(i);
                    hr_l.push_back(hr_len[i]);
                    hr_len[i] = 0;
                end
                if (bus.cfg_start[i]) begin
                    start_cnt[i]++;
                    last_start[i] = cyc;
                    if (respond[i]) done_at[i] = cyc + dly[i];
                end
                if (done_at[i] == cyc) bus.cfg_done[i] = 1'b1;
            end
            if (bus.grant_valid && bus.grant_ready) begin
                grant_q.push_back(int'(bus.grant_sel));
                grant_cyc.push_back(cyc);
            end
        end
    end

    // Round-robin reference: serve every pending sensor, each time the first one after the last served.
    function automatic void rr_expect(input bit [N-1:0] pend, input int last);
        int j;
        logic [1:0] b;
        while (pend != '0) begin
            j = -1;
            for (int k = 1; k <= N && j < 0; k++) begin
                b = 2'((last + k + N) % N);
                if (pend[b]) j = int'(b);
            end
            exp_q.push_back(j);
            pend[2'(j)] = 1'b0;
            last = j;
        end
        model_last = last;
    endfunction

    task automatic cmp_grants();
        chk("grant_count", grant_q.size(), exp_q.size());
        foreach (exp_q[k]) begin
            if (k < grant_q.size()) begin
                chk("grant_sel", grant_q[k], exp_q[k]);
                if (k > 0) chk("grant_gap", grant_cyc[k] - grant_cyc[k-1], 2);
            end
        end
    endtask

    task automatic run_cfg(input bit [N-1:0] resp, input int fixed_dly);
        int e, nfail, att;
        bit [N-1:0] nr;
        enable = 1'b0;
        steps(2);
        clear_mon();
        respond = resp;
        for (int i = 0; i < N; i++) dly[i] = fixed_dly > 0 ? fixed_dly : int'($urandom_range(1, 200));
        enable = 1'b1;
        model_last = -1;
        for (int k = 0; k < 30000 && !all_done; k++) step();
        chk("all_done", int'(all_done), 1);
        e = 0;
        nfail = 0;
        for (int i = 0; i < N; i++) begin
            att = resp[i] ? 1 : M;
            if (!resp[i]) nfail++;
            chk("start_cnt", start_cnt[i], att);
            for (int a = 0; a < att; a++) begin
                if (e < hr_s.size()) begin
                    chk("hr_sensor", hr_s[e], i);
                    chk("hr_len", hr_l[e], H);
                end
                e++;
            end
        end
        chk("hr_count", hr_s.size(), e);
        chk("gap_count", gap_q.size(), nfail * (M - 1));
        foreach (gap_q[g]) chk("retry_gap", gap_q[g], T + 1);
        nr = ~resp;
        chk("sensor_ok", int'(sensor_ok), int'(resp));
        chk("sensor_failed", int'(sensor_failed), int'(nr));
        chk("start_watch", int'(bus.start_watch), int'(resp));
        chk("busy_run", int'(busy), 0);
    endtask

    task automatic arb_round(input bit [N-1:0] mask);
        grant_q.delete();
        grant_cyc.delete();
        exp_q.delete();
        bus.grant_ready = 1'b1;
        bus.capture_done = mask;
        step();
        bus.capture_done = '0;
        steps(12);
        rr_expect(mask & sensor_ok, model_last);
        cmp_grants();
    endtask

    task automatic hold_round(input bit [N-1:0] mask);
        int g, viol;
        bit [N-1:0] pend;
        grant_q.delete();
        grant_cyc.delete();
        exp_q.delete();
        pend = mask & sensor_ok;
        bus.grant_ready = 1'b0;
        bus.capture_done = mask;
        step();
        bus.capture_done = '0;
        step();
        rr_expect(pend, model_last);
        g = exp_q[0];
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.grant_valid || int'(bus.grant_sel) != g) viol++;
            step();
        end
        chk("hold_stable", viol, 0);
        bus.grant_ready = 1'b1;
        bus.capture_done = 4'(1) << g;
        step();
        bus.capture_done = '0;
        steps(12);
        exp_q.delete();
        exp_q.push_back(g);
        rr_expect(pend, g);
        cmp_grants();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    initial begin
        bus.capture_done = '0;
        bus.grant_ready = 1'b0;
        for (int i = 0; i < N; i++) dly[i] = 100;
        steps(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(all_done), 0);
        chk("rst_hr", int'(bus.hard_reset), 0);
        chk("rst_ok", int'({sensor_ok, sensor_failed}), 0);
        chk("rst_grant", int'({bus.grant_valid, bus.grant_sel}), 0);
        reset_n = 1'b1;
        step();

        run_cfg(4'b1111, 100);
        arb_round(4'b1011);
        hold_round(4'b0011);
        for (int r = 0; r < 3; r++) arb_round(4'($urandom));

        run_cfg(4'b1011, 100);
        arb_round(4'b1111);
        arb_round(4'($urandom));

        for (int r = 0; r < 2; r++) begin
            run_cfg(4'($urandom), 0);
            arb_round(4'($urandom));
        end

        enable = 1'b0;
        steps(2);
        clear_mon();
        respond = 4'b1101;
        for (int i = 0; i < N; i++) dly[i] = 100;
        enable = 1'b1;
        for (int k = 0; k < 5000 && start_cnt[1] == 0; k++) step();
        chk("s1_started", start_cnt[1], 1);
        steps(50);
        chk("mid_ok", int'(sensor_ok), 1);
        chk("mid_busy", int'(busy), 1);
        enable = 1'b0;
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(all_done), 0);
        chk("abort_outs", int'({bus.hard_reset, bus.cfg_start, bus.start_watch}), 0);
        chk("abort_gv", int'(bus.grant_valid), 0);
        chk("abort_ok", int'(sensor_ok), 1);
        steps(5);
        chk("held_ok", int'(sensor_ok), 1);
        enable = 1'b1;
        step();
        chk("restart_ok", int'(sensor_ok), 0);
        chk("restart_hr", int'(bus.hard_reset), 1);
        chk("restart_busy", int'(busy), 1);

        steps(200);
        chk("mid_hrst", int'(bus.hard_reset), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_hr", int'(bus.hard_reset), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_outs", int'({bus.cfg_start, bus.start_watch, bus.grant_valid, sensor_ok, sensor_failed, all_done}), 0);
        enable = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ts4231_cfg_scheduler.md
TS4231_CFG_SCHEDULER -- requirements
Module: ts4231_cfg_scheduler

Interface
REQ-001 Parameter NUMBER_OF_SENSORS, default 4: number of TS4231 front-ends sequenced (N, 1..16).
REQ-002 Parameter HARD_RESET_CYCLES, default 480: hard-reset pulse length in clock cycles (10 us at 48 MHz).
REQ-003 Parameter CFG_TIMEOUT_CYCLES, default 4_800_000: maximum wait for cfg_done per attempt (100 ms at 48 MHz).
REQ-004 Parameter MAX_RETRIES, default 3: configuration attempts per sensor before it is declared failed.
REQ-005 clock  in  1  single system clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  level; high runs the sequence, low aborts to IDLE.
REQ-008 hard_reset  out  N  per-sensor hard-reset strobe to the init engine.
REQ-009 cfg_start  out  N  per-sensor one-cycle configuration start pulse.
REQ-010 cfg_done  in  N  per-sensor configuration-complete level.
REQ-011 start_watch  out  N  per-sensor watch enable.
REQ-012 capture_done  in  N  per-sensor one-cycle capture-complete pulse.
REQ-013 grant_sel  out  clog2(N) (min 1)  index of the sensor whose capture is offered.
REQ-014 grant_valid  out  1  grant_sel is valid; ready/valid handshake.
REQ-015 grant_ready  in  1  consumer accepts the offered index.
REQ-016 sensor_ok / sensor_failed  out  N each  per-sensor configuration result.
REQ-017 busy  out  1  high in every state except IDLE and RUN; all_done  out  1  high in RUN.

Function
REQ-018 States SHALL be IDLE, HRST, START, WAIT_DONE, NEXT, RUN; an index register idx selects the active sensor.
REQ-019 In IDLE with enable=1, the FSM SHALL clear sensor_ok/sensor_failed, set idx=0 and retry=0, and enter HRST next cycle.
REQ-020 HRST SHALL drive hard_reset[idx]=1 for exactly HARD_RESET_CYCLES cycles, then enter START.
REQ-021 START SHALL drive cfg_start[idx]=1 for exactly one cycle, clear the timeout counter and enter WAIT_DONE.
REQ-022 In WAIT_DONE, cfg_done[idx]=1 SHALL set sensor_ok[idx] and enter NEXT; cfg_done takes priority over a coincident timeout.
REQ-023 When the timeout counter reaches CFG_TIMEOUT_CYCLES-1 without cfg_done, retry SHALL increment; retry<MAX_RETRIES -> HRST, else set sensor_failed[idx] and enter NEXT.
REQ-024 NEXT SHALL zero retry; idx==N-1 -> RUN, else idx increments and enters HRST.
REQ-025 In RUN, start_watch[i] SHALL equal sensor_ok[i] and remain high while in RUN.
REQ-026 In RUN, capture_done[i] of an ok sensor SHALL set pending[i]; capture_done of failed sensors and any capture_done outside RUN SHALL be ignored.
REQ-027 Arbitration SHALL be round-robin: the first pending index strictly after the last granted index, wrapping from N-1 to 0; the first grant after entering RUN searches from index 0.
REQ-028 grant_valid and grant_sel SHALL be registered and SHALL stay stable until grant_valid&grant_ready, one cycle after a pending bit is set.
REQ-029 On handshake, pending[grant_sel] SHALL clear unless capture_done[grant_sel] coincides, in which case it stays set.
REQ-030 A new grant SHALL be offered no earlier than the cycle after a handshake; at most one grant SHALL be outstanding.
REQ-031 enable=0 in any state SHALL enter IDLE next cycle, deassert hard_reset, cfg_start, start_watch and grant_valid, and clear pending; sensor_ok/sensor_failed SHALL hold.
REQ-032 Counters SHALL be sized clog2(max value+1) and SHALL never wrap.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE and set idx, retry, counters, pending, the round-robin pointer and every output to 0.
REQ-034 Deassertion SHALL be synchronised externally; the block SHALL take no action on the first edge after release other than evaluating enable.

Structure
REQ-035 Package ts4231_pkg SHALL hold the state enum and default timing constants shared with the init engine.
REQ-036 Round-robin selection SHALL be a sub-module ts4231_rr_arbiter (request vector, pointer, grant index, any-request).

Verification
REQ-037 N=4, all cfg_done respond 100 cycles after cfg_start -> four sequences, each with hard_reset high exactly HARD_RESET_CYCLES cycles, then sensor_ok=4'b1111, all_done=1, start_watch=4'b1111.
REQ-038 Sensor 2 never asserts cfg_done, CFG_TIMEOUT_CYCLES=1000 -> three attempts on sensor 2, sensor_failed=4'b0100, start_watch=4'b1011.
REQ-039 RUN, capture_done on sensors 0,1,3 in the same cycle, grant_ready held high -> grant_sel sequence 0,1,3, one cycle between handshakes.
REQ-040 grant_ready held low 20 cycles with grant_valid high -> grant_sel stable; a capture_done on the granted sensor at handshake re-offers it on its next round-robin turn.
REQ-041 enable dropped mid-WAIT_DONE on sensor 1 -> IDLE next cycle, outputs low, sensor_ok=4'b0001 held; re-raising enable restarts at sensor 0 with status cleared.
REQ-042 reset_n pulsed low mid-HRST -> hard_reset and all outputs 0 immediately, FSM in IDLE.
